// File: rtl/line_mem_responder.sv
// Memory-side responder for the 256-bit cache line interface: one access at a time,
// fixed latency, single-cycle ack, sticky range error and saturating access counters.
module line_mem_responder #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o,
   output logic         err_o,
   output logic [15:0]  rd_count_o,
   output logic [15:0]  wr_count_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t        state_reg, state_next;
   logic [7:0]    count_reg, count_next;
   logic          accept, finish, in_range;
   logic          write_reg;
   logic [26:0]   index_reg;
   logic [255:0]  wdata_reg;
   logic [255:0]  mem [DEPTH];
   logic          unused_addr;

   assign unused_addr = ^addr_i[4:0];

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable_i) begin
               accept     = 1'b1;
               state_next = BUSY;
               count_next = 8'(LATENCY - 1);
            end
         end
         BUSY: begin
            // The edge leaving count 1 is both the commit/read edge and ACK entry.
            if (count_reg == 8'd1) begin
               finish     = 1'b1;
               state_next = ACK;
               count_next = 8'd0;
            end else begin
               count_next = count_reg - 8'd1;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_range = ({5'd0, index_reg} < 32'(DEPTH));
   assign ack_o    = (state_reg == ACK);

   // Request latch and line array carry no reset; the array must survive rst_i.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         write_reg <= write_i;
         index_reg <= addr_i[31:5];
         wdata_reg <= data_i;
      end
      if (finish && write_reg && in_range) begin
         mem[index_reg[AW-1:0]] <= wdata_reg;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg  <= IDLE;
         count_reg  <= 8'd0;
         data_o     <= '0;
         err_o      <= 1'b0;
         rd_count_o <= 16'd0;
         wr_count_o <= 16'd0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         if (finish) begin
            if (!in_range) begin
               err_o <= 1'b1;
            end
            if (write_reg) begin
               if (wr_count_o != 16'hFFFF) begin
                  wr_count_o <= wr_count_o + 16'd1;
               end
            end else begin
               data_o <= in_range ? mem[index_reg[AW-1:0]] : '0;
               if (rd_count_o != 16'hFFFF) begin
                  rd_count_o <= rd_count_o + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized self-checking bench for line_mem_responder against an array-based
// reference model of line reads/writes, range errors and saturating counters.
module tb_line_mem_responder;

   localparam int L = 10;
   localparam int D = 512;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         enable_i = 1'b0;
   logic         write_i = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [255:0] data_i = '0;
   logic         ack_o;
   logic [255:0] data_o;
   logic         err_o;
   logic [15:0]  rd_count_o;
   logic [15:0]  wr_count_o;

   line_mem_responder #(.LATENCY(L), .DEPTH(D)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .enable_i   (enable_i),
      .write_i    (write_i),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .ack_o      (ack_o),
      .data_o     (data_o),
      .err_o      (err_o),
      .rd_count_o (rd_count_o),
      .wr_count_o (wr_count_o)
   );

   always #5 clk_i = ~clk_i;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [255:0] ref_mem [D];
   logic [255:0] exp_data = '0;
   logic [15:0]  exp_rd = '0;
   logic [15:0]  exp_wr = '0;
   logic         exp_err = 1'b0;
   bit           post_ack = 1'b0;
   time          ack_t = 0;

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge inside the ack cycle.
   task automatic access(input bit w, input logic [31:0] a, input logic [255:0] d, input bit hold);
      int          n;
      logic [26:0] idx;
      enable_i = 1'b1;
      write_i  = w;
      addr_i   = a;
      data_i   = d;
      if (post_ack) begin
         @(posedge clk_i);
         #1 check("ack_len", 256'(ack_o), 256'(0));
      end
      @(posedge clk_i);
      #1;
      write_i = 1'($urandom);
      addr_i  = $urandom;
      data_i  = rnd256();
      if (!hold) enable_i = 1'b0;
      n = 0;
      do begin
         @(posedge clk_i);
         n++;
         @(negedge clk_i);
      end while (!ack_o && n < 300);
      ack_t = $time;
      check("ack_latency", 256'(n), 256'(L - 1));
      idx = a[31:5];
      if (w) begin
         if (idx < D) ref_mem[idx] = d;
         if (exp_wr != 16'hFFFF) exp_wr++;
      end else begin
         exp_data = (idx < D) ? ref_mem[idx] : '0;
         if (exp_rd != 16'hFFFF) exp_rd++;
      end
      if (idx >= D) exp_err = 1'b1;
      check("data_o", data_o, exp_data);
      check("rd_count", 256'(rd_count_o), 256'(exp_rd));
      check("wr_count", 256'(wr_count_o), 256'(exp_wr));
      check("err_o", 256'(err_o), 256'(exp_err));
      $display("txn %s addr=%h lat=%0d rd=%0d wr=%0d err=%0d", w ? "WR" : "RD", a, n,
               rd_count_o, wr_count_o, err_o);
      post_ack = 1'b1;
   endtask

   task automatic rest(input int cycles);
      enable_i = 1'b0;
      if (post_ack) begin
         @(posedge clk_i);
         #1 check("ack_len", 256'(ack_o), 256'(0));
         post_ack = 1'b0;
      end
      repeat (cycles) @(negedge clk_i);
   endtask

   initial begin
      logic [255:0] v;
      logic [255:0] line0;
      time          t1;
      int           idx;

      #1;
      for (int i = 0; i < D; i++) begin
         v = rnd256();
         dut.mem[i] = v;
         ref_mem[i] = v;
      end
      v = {32{8'hA5}};
      dut.mem[3] = v;
      ref_mem[3] = v;
      #3;
      check("rst_ack", 256'(ack_o), 256'(0));
      check("rst_data", data_o, 256'(0));
      check("rst_err", 256'(err_o), 256'(0));
      check("rst_rd", 256'(rd_count_o), 256'(0));
      check("rst_wr", 256'(wr_count_o), 256'(0));
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);

      // Preloaded read, write-then-read, ignored offset bits
      access(1'b0, 32'h0000_0060, '0, 1'b0);
      rest(1);
      access(1'b1, 32'h0000_0100, 256'h1234, 1'b0);
      rest(2);
      access(1'b0, 32'h0000_0100, '0, 1'b0);
      rest(1);
      access(1'b0, 32'h0000_011F, '0, 1'b0);
      rest(1);

      // Back-to-back reads with enable held high
      access(1'b0, 32'h0000_0020, '0, 1'b1);
      t1 = ack_t;
      access(1'b0, 32'h0000_0040, '0, 1'b1);
      check("b2b_spacing", 256'(ack_t - t1), 256'((L + 1) * 10));
      t1 = ack_t;
      access(1'b0, 32'h0000_0060, '0, 1'b1);
      check("b2b_spacing", 256'(ack_t - t1), 256'((L + 1) * 10));
      rest(1);

      // Out-of-range write and read of index 512; line 0 must not alias
      line0 = ref_mem[0];
      access(1'b1, 32'h0000_4000, rnd256(), 1'b0);
      rest(1);
      access(1'b0, 32'h0000_4000, '0, 1'b0);
      rest(1);
      access(1'b0, 32'h0000_0000, '0, 1'b0);
      check("line0_kept", data_o, line0);
      rest(2);

      // Reset during BUSY at countdown 4
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_00E0;
      data_i   = rnd256();
      @(posedge clk_i);
      #1 enable_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      check("abort_ack", 256'(ack_o), 256'(0));
      check("abort_data", data_o, 256'(0));
      check("abort_err", 256'(err_o), 256'(0));
      check("abort_rd", 256'(rd_count_o), 256'(0));
      check("abort_wr", 256'(wr_count_o), 256'(0));
      exp_data = '0;
      exp_rd   = '0;
      exp_wr   = '0;
      exp_err  = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         check("abort_noack", 256'(ack_o), 256'(0));
      end
      rst_i = 1'b1;
      repeat (L + 4) begin
         @(negedge clk_i);
         check("abort_noack", 256'(ack_o), 256'(0));
      end
      access(1'b0, 32'h0000_00E0, '0, 1'b0);
      rest(1);

      // Write counter saturation
      force dut.wr_count_o = 16'hFFFE;
      @(negedge clk_i);
      release dut.wr_count_o;
      @(negedge clk_i);
      exp_wr = 16'hFFFE;
      check("wr_preset", 256'(wr_count_o), 256'(exp_wr));
      access(1'b1, 32'h0000_0200, rnd256(), 1'b0);
      rest(1);
      access(1'b1, 32'h0000_0220, rnd256(), 1'b0);
      rest(2);

      // Randomized mix, including back-to-back and out-of-range accesses
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(7, 0) == 0) idx = 512 + int'($urandom_range(600, 0));
         else                           idx = int'($urandom_range(D - 1, 0));
         access(1'($urandom), {idx[26:0], 5'($urandom)}, rnd256(), 1'($urandom));
         if ($urandom_range(2, 0) == 0) rest(int'($urandom_range(3, 1)));
      end
      rest(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
